// File: rtl/xm_alu_pkg.sv
// Shared encodings for the multi-cycle XMakina ALU: block/func codes, FSM states, flag bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xm_alu_pkg;

    // Functional block selector
    localparam logic [1:0] ALU_ARITH = 2'd0;
    localparam logic [1:0] ALU_LOGIC = 2'd1;
    localparam logic [1:0] ALU_SHIFT = 2'd2;
    localparam logic [1:0] ALU_MOVE  = 2'd3;

    // Arithmetic block functions
    localparam logic [1:0] FUNC_ADD  = 2'd0;
    localparam logic [1:0] FUNC_ADDC = 2'd1;
    localparam logic [1:0] FUNC_SUB  = 2'd2;
    localparam logic [1:0] FUNC_SUBC = 2'd3;

    // Logic block functions
    localparam logic [1:0] FUNC_XOR  = 2'd0;
    localparam logic [1:0] FUNC_AND  = 2'd1;
    localparam logic [1:0] FUNC_BIC  = 2'd2;
    localparam logic [1:0] FUNC_BIS  = 2'd3;

    // Shifter block functions
    localparam logic [1:0] FUNC_SRA  = 2'd0;
    localparam logic [1:0] FUNC_RRC  = 2'd1;
    localparam logic [1:0] FUNC_SXT  = 2'd2;
    localparam logic [1:0] FUNC_MUL  = 2'd3;

    // Move block functions
    localparam logic [1:0] FUNC_MOV  = 2'd0;
    localparam logic [1:0] FUNC_MOVZ = 2'd1;
    localparam logic [1:0] FUNC_MOVS = 2'd2;
    localparam logic [1:0] FUNC_SWPB = 2'd3;

    // Control FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_MUL    = 2'd2;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/xm_alu_iter.sv
// Iterative datapath: one-bit-per-step SRA/RRC and (with XM_ALU_MUL_EN) shift-add multiply.
// Latency: one step per cycle; val/carry_out present the value the final step produces.
// Backpressure: none; the owner asserts load once, then step until last.
module xm_alu_iter
    import xm_alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BYTE_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [1:0]         mode,
    input  logic               byte_op,
    input  logic [DATA_W-1:0]  opa,
    input  logic [DATA_W-1:0]  opb,
    input  logic [SHAMT_W:0]   cnt_init,
    input  logic               carry_in,
    output logic               last,
    output logic [DATA_W-1:0]  val,
    output logic               carry_out
);

    localparam logic [DATA_W-1:0] BYTE_MASK = {{(DATA_W-BYTE_W){1'b0}}, {BYTE_W{1'b1}}};

    logic [DATA_W-1:0] sreg, sreg_nxt;
    logic [SHAMT_W:0]  cnt;
    logic              cbit, cbit_nxt, msb_in;
    logic              byte_q;
    logic [1:0]        mode_q;
`ifdef XM_ALU_MUL_EN
    logic [DATA_W-1:0]   acc, acc_nxt, mcand, mcand_eff;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [2*BYTE_W-1:0] bprod;
`endif

    assign last = (cnt == (SHAMT_W+1)'(1));

    // Next value of the working registers for one step, plus the value exposed to the owner
    always_comb begin
        sreg_nxt  = sreg;
        msb_in    = (mode_q == FUNC_RRC) ? cbit : (byte_q ? sreg[BYTE_W-1] : sreg[DATA_W-1]);
        if (byte_q) begin
            sreg_nxt[BYTE_W-1:0] = {msb_in, sreg[BYTE_W-1:1]};
        end else begin
            sreg_nxt = {msb_in, sreg[DATA_W-1:1]};
        end
        cbit_nxt  = sreg[0];
        val       = sreg_nxt;
        carry_out = cbit_nxt;
`ifdef XM_ALU_MUL_EN
        // Right-shifting product register {acc, sreg}: the multiplier drains out of sreg
        // while product bits fill in from the top.
        mcand_eff = byte_q ? (mcand & BYTE_MASK) : mcand;
        acc_nxt   = acc;
        sum       = '0;
        prod      = '0;
        bprod     = '0;
        if (mode_q == FUNC_MUL) begin
            sum      = {1'b0, acc} + (sreg[0] ? {1'b0, mcand_eff} : '0);
            acc_nxt  = sum[DATA_W:1];
            sreg_nxt = {sum[0], sreg[DATA_W-1:1]};
            prod     = {acc_nxt, sreg_nxt};
            if (byte_q) begin
                // After BYTE_W steps the byte product sits DATA_W-BYTE_W bits up
                bprod     = prod[DATA_W-BYTE_W +: 2*BYTE_W];
                val       = {mcand[DATA_W-1:BYTE_W], bprod[BYTE_W-1:0]};
                carry_out = |bprod[2*BYTE_W-1:BYTE_W];
            end else begin
                val       = prod[DATA_W-1:0];
                carry_out = |prod[2*DATA_W-1:DATA_W];
            end
        end
`endif
    end

    // Load operands on accept, then advance one step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg   <= '0;
            cnt    <= '0;
            cbit   <= 1'b0;
            byte_q <= 1'b0;
            mode_q <= '0;
`ifdef XM_ALU_MUL_EN
            acc    <= '0;
            mcand  <= '0;
`endif
        end else if (load) begin
            sreg   <= (mode == FUNC_MUL) ? (byte_op ? (opb & BYTE_MASK) : opb) : opa;
            cnt    <= cnt_init;
            cbit   <= carry_in;
            byte_q <= byte_op;
            mode_q <= mode;
`ifdef XM_ALU_MUL_EN
            acc    <= '0;
            mcand  <= opa;
`endif
        end else if (step) begin
            sreg   <= sreg_nxt;
            cbit   <= cbit_nxt;
            cnt    <= cnt - (SHAMT_W+1)'(1);
`ifdef XM_ALU_MUL_EN
            acc    <= acc_nxt;
`endif
        end
    end

endmodule

// File: rtl/xm_alu_mc.sv
// Multi-cycle XMakina ALU (arith/logic/shift/move, byte/word) with registered result and flags; XM_ALU_MUL_EN adds shift-add multiply.
// Latency: 1 cycle for single-cycle ops, N+1 for N-bit SRA/RRC, DATA_W+1 (BYTE_W+1 byte) for multiply.
// Backpressure: ready low while iterating; start is only taken when ready=1, done pulses one cycle.
module xm_alu_mc
    import xm_alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int BYTE_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [1:0]        block_sel,
    input  logic [1:0]        block_func,
    input  logic              byte_op,
    input  logic              carry_in,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              neg,
    output logic              ovf
);

    localparam int BSH_W = $clog2(BYTE_W);

    logic [1:0]        state;
    logic              go;
    logic              op_byte_q;
    flags_t            flg_q, sc_flg, it_flg;
    logic [DATA_W-1:0] sc_val, b_eff, lg, tmp;
    logic [DATA_W:0]   sum_w;
    logic [BYTE_W:0]   sum_b;
    logic              cin_eff, sc_carry, sc_ovf, flag_byte, illegal, is_iter, is_mul;
    logic [SHAMT_W:0]  shamt, it_cnt;
    logic              it_last, it_carry;
    logic [DATA_W-1:0] it_val;

    assign ready = (state == ST_IDLE);
    assign go    = start & ready;
    assign carry = flg_q.carry;
    assign zero  = flg_q.zero;
    assign neg   = flg_q.neg;
    assign ovf   = flg_q.ovf;

    // Shift count, masked to the byte range in byte mode
    always_comb begin
        shamt = '0;
        if (byte_op) begin
            shamt[BSH_W-1:0] = src_b[BSH_W-1:0];
        end else begin
            shamt[SHAMT_W-1:0] = src_b[SHAMT_W-1:0];
        end
    end

    // Single-cycle result/flags and the decision whether the op needs the iterative datapath
    always_comb begin
        sc_val    = '0;
        sc_carry  = carry_in;
        sc_ovf    = 1'b0;
        flag_byte = byte_op;
        illegal   = 1'b0;
        is_iter   = 1'b0;
        is_mul    = 1'b0;
        b_eff     = '0;
        cin_eff   = 1'b0;
        sum_w     = '0;
        sum_b     = '0;
        lg        = '0;
        tmp       = '0;
        case (block_sel)
            ALU_ARITH: begin
                b_eff = block_func[1] ? ~src_b : src_b;
                case (block_func)
                    FUNC_ADD:  cin_eff = 1'b0;
                    FUNC_ADDC: cin_eff = carry_in;
                    FUNC_SUB:  cin_eff = 1'b1;
                    FUNC_SUBC: cin_eff = carry_in;
                endcase
                sum_w = {1'b0, src_a} + {1'b0, b_eff} + (DATA_W+1)'(cin_eff);
                sum_b = {1'b0, src_a[BYTE_W-1:0]} + {1'b0, b_eff[BYTE_W-1:0]} + (BYTE_W+1)'(cin_eff);
                if (byte_op) begin
                    sc_val   = {src_b[DATA_W-1:BYTE_W], sum_b[BYTE_W-1:0]};
                    sc_carry = sum_b[BYTE_W];
                    sc_ovf   = (src_a[BYTE_W-1] == b_eff[BYTE_W-1]) && (sum_b[BYTE_W-1] != src_a[BYTE_W-1]);
                end else begin
                    sc_val   = sum_w[DATA_W-1:0];
                    sc_carry = sum_w[DATA_W];
                    sc_ovf   = (src_a[DATA_W-1] == b_eff[DATA_W-1]) && (sum_w[DATA_W-1] != src_a[DATA_W-1]);
                end
            end
            ALU_LOGIC: begin
                case (block_func)
                    FUNC_XOR: lg = src_a ^ src_b;
                    FUNC_AND: lg = src_a & src_b;
                    FUNC_BIC: lg = src_a & ~src_b;
                    FUNC_BIS: lg = src_a | src_b;
                endcase
                sc_val = byte_op ? {src_b[DATA_W-1:BYTE_W], lg[BYTE_W-1:0]} : lg;
            end
            ALU_SHIFT: begin
                case (block_func)
                    FUNC_SRA, FUNC_RRC: begin
                        // A zero count completes immediately with the operand untouched
                        sc_val  = src_a;
                        is_iter = (shamt != '0);
                    end
                    FUNC_SXT: begin
                        tmp    = {{(DATA_W-BYTE_W){src_a[BYTE_W-1]}}, src_a[BYTE_W-1:0]};
                        sc_val = byte_op ? {src_a[DATA_W-1:BYTE_W], tmp[BYTE_W-1:0]} : tmp;
                    end
                    FUNC_MUL: begin
`ifdef XM_ALU_MUL_EN
                        is_iter = 1'b1;
                        is_mul  = 1'b1;
`else
                        sc_val  = src_b;
                        illegal = 1'b1;
`endif
                    end
                endcase
            end
            ALU_MOVE: begin
                flag_byte = 1'b0;
                case (block_func)
                    FUNC_MOV:  sc_val = src_b;
                    FUNC_MOVZ: sc_val = {{(DATA_W-BYTE_W){1'b0}}, src_b[BYTE_W-1:0]};
                    FUNC_MOVS: sc_val = {{(DATA_W-BYTE_W){src_b[BYTE_W-1]}}, src_b[BYTE_W-1:0]};
                    FUNC_SWPB: begin
                        tmp = src_b;
                        tmp[2*BYTE_W-1:0] = {src_b[BYTE_W-1:0], src_b[2*BYTE_W-1:BYTE_W]};
                        sc_val = tmp;
                    end
                endcase
            end
        endcase
        sc_flg.carry = sc_carry;
        sc_flg.ovf   = sc_ovf;
        sc_flg.neg   = flag_byte ? sc_val[BYTE_W-1] : sc_val[DATA_W-1];
        sc_flg.zero  = flag_byte ? (sc_val[BYTE_W-1:0] == '0) : (sc_val == '0);
        if (illegal) begin
            sc_flg = '0;
        end
        it_cnt = is_mul ? (byte_op ? (SHAMT_W+1)'(BYTE_W) : (SHAMT_W+1)'(DATA_W)) : shamt;
    end

    // Flags for the value the iterative datapath finishes with
    always_comb begin
        it_flg.carry = it_carry;
        it_flg.ovf   = 1'b0;
        it_flg.neg   = op_byte_q ? it_val[BYTE_W-1] : it_val[DATA_W-1];
        it_flg.zero  = op_byte_q ? (it_val[BYTE_W-1:0] == '0) : (it_val == '0);
    end

    xm_alu_iter #(
        .DATA_W  (DATA_W),
        .BYTE_W  (BYTE_W),
        .SHAMT_W (SHAMT_W)
    ) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (go & is_iter),
        .step      (state != ST_IDLE),
        .mode      (block_func),
        .byte_op   (byte_op),
        .opa       (src_a),
        .opb       (src_b),
        .cnt_init  (it_cnt),
        .carry_in  (carry_in),
        .last      (it_last),
        .val       (it_val),
        .carry_out (it_carry)
    );

    // Control FSM and output registers; results hold until the next done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            result    <= '0;
            flg_q     <= '0;
            op_byte_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        if (is_iter) begin
                            op_byte_q <= byte_op;
                            state     <= is_mul ? ST_MUL : ST_SHIFT;
                        end else begin
                            result <= sc_val;
                            flg_q  <= sc_flg;
                            done   <= 1'b1;
                        end
                    end
                end
                ST_SHIFT, ST_MUL: begin
                    if (it_last) begin
                        result <= it_val;
                        flg_q  <= it_flg;
                        done   <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xm_alu_mc.sv
// Directed bench for xm_alu_mc: word/byte arith, logic, move, multi-cycle shifts, handshake, reset abort, func 3.
// Latency: checks done latency and ready-low cycles per operation.
// Backpressure: waits on done with a bounded cycle budget.
module tb_xm_alu_mc;
    import xm_alu_pkg::*;

    typedef struct packed {
        logic [1:0]  sel;
        logic [1:0]  fn;
        logic        byt;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;   // {C,Z,N,V}
        logic [5:0]  lat;
    } vec_t;

    logic        clk, rst_n, start, ready, byte_op, carry_in, done;
    logic [1:0]  block_sel, block_func;
    logic [15:0] src_a, src_b, result;
    logic        carry, zero, neg, ovf;
    int          errors = 0;
    int          checks = 0;

    xm_alu_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .block_sel  (block_sel),
        .block_func (block_func),
        .byte_op    (byte_op),
        .carry_in   (carry_in),
        .src_a      (src_a),
        .src_b      (src_b),
        .done       (done),
        .result     (result),
        .carry      (carry),
        .zero       (zero),
        .neg        (neg),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op and wait (bounded) for done; returns observed result, flags, latency, ready-low cycles
    task automatic exec(input vec_t v, output logic [15:0] r, output logic [3:0] f,
                        output int lat, output int rlow);
        @(negedge clk);
        block_sel  = v.sel;
        block_func = v.fn;
        byte_op    = v.byt;
        carry_in   = v.cin;
        src_a      = v.a;
        src_b      = v.b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        rlow  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (ready === 1'b0) rlow++;
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = {carry, zero, neg, ovf};
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; block_sel = '0; block_func = '0;
        byte_op = 1'b0; carry_in = 1'b0; src_a = '0; src_b = '0;
        #12;
        checks++; if (ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", ready); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); errors++; end
        checks++; if (result !== 16'h0000) begin $display("FAIL reset_result got %h want 0000", result); errors++; end
        checks++; if ({carry, zero, neg, ovf} !== 4'b0000) begin
            $display("FAIL reset_flags got %b want 0000", {carry, zero, neg, ovf}); errors++; end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith;
        vec_t v [6];
        logic [15:0] r; logic [3:0] f; int lat, rl;
        v[0] = '{ALU_ARITH, FUNC_ADD,  1'b0, 1'b0, 16'h007F, 16'h007F, 16'h00FE, 4'b0000, 6'd1};
        v[1] = '{ALU_ARITH, FUNC_SUB,  1'b0, 1'b0, 16'h007F, 16'h007F, 16'h0000, 4'b1100, 6'd1};
        v[2] = '{ALU_ARITH, FUNC_ADD,  1'b1, 1'b0, 16'h007F, 16'hAB7F, 16'hABFE, 4'b0011, 6'd1};
        v[3] = '{ALU_ARITH, FUNC_ADD,  1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0011, 6'd1};
        v[4] = '{ALU_ARITH, FUNC_SUBC, 1'b0, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010, 6'd1};
        v[5] = '{ALU_ARITH, FUNC_ADDC, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b1100, 6'd1};
        for (int i = 0; i < 6; i++) begin
            exec(v[i], r, f, lat, rl);
            checks++; if (r !== v[i].res) begin $display("FAIL arith[%0d] result got %h want %h", i, r, v[i].res); errors++; end
            checks++; if (f !== v[i].flg) begin $display("FAIL arith[%0d] flags got %b want %b", i, f, v[i].flg); errors++; end
            checks++; if (lat !== int'(v[i].lat)) begin $display("FAIL arith[%0d] latency got %0d want %0d", i, lat, v[i].lat); errors++; end
        end
    endtask

    task automatic test_logic_move;
        vec_t v [8];
        logic [15:0] r; logic [3:0] f; int lat, rl;
        v[0] = '{ALU_LOGIC, FUNC_XOR,  1'b0, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 4'b1000, 6'd1};
        v[1] = '{ALU_LOGIC, FUNC_BIC,  1'b0, 1'b0, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0010, 6'd1};
        v[2] = '{ALU_LOGIC, FUNC_AND,  1'b1, 1'b0, 16'h12FF, 16'hAB0F, 16'hAB0F, 4'b0000, 6'd1};
        v[3] = '{ALU_LOGIC, FUNC_BIS,  1'b1, 1'b0, 16'h0000, 16'hAB00, 16'hAB00, 4'b0100, 6'd1};
        v[4] = '{ALU_MOVE,  FUNC_MOVS, 1'b0, 1'b0, 16'h0000, 16'h00AA, 16'hFFAA, 4'b0010, 6'd1};
        v[5] = '{ALU_MOVE,  FUNC_SWPB, 1'b0, 1'b0, 16'h0000, 16'h12AB, 16'hAB12, 4'b0010, 6'd1};
        v[6] = '{ALU_MOVE,  FUNC_MOVZ, 1'b1, 1'b1, 16'h0000, 16'hFFAA, 16'h00AA, 4'b1000, 6'd1};
        v[7] = '{ALU_MOVE,  FUNC_MOV,  1'b0, 1'b0, 16'h5555, 16'h0000, 16'h0000, 4'b0100, 6'd1};
        for (int i = 0; i < 8; i++) begin
            exec(v[i], r, f, lat, rl);
            checks++; if (r !== v[i].res) begin $display("FAIL logmov[%0d] result got %h want %h", i, r, v[i].res); errors++; end
            checks++; if (f !== v[i].flg) begin $display("FAIL logmov[%0d] flags got %b want %b", i, f, v[i].flg); errors++; end
            checks++; if (lat !== int'(v[i].lat)) begin $display("FAIL logmov[%0d] latency got %0d want %0d", i, lat, v[i].lat); errors++; end
        end
    endtask

    task automatic test_shift;
        vec_t v [8];
        logic [15:0] r; logic [3:0] f; int lat, rl;
        v[0] = '{ALU_SHIFT, FUNC_SRA, 1'b0, 1'b0, 16'h8000, 16'h0004, 16'hF800, 4'b0010, 6'd5};
        v[1] = '{ALU_SHIFT, FUNC_SRA, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h8000, 4'b1010, 6'd1};
        v[2] = '{ALU_SHIFT, FUNC_RRC, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h8000, 4'b1010, 6'd2};
        v[3] = '{ALU_SHIFT, FUNC_RRC, 1'b1, 1'b1, 16'hAB01, 16'h0001, 16'hAB80, 4'b1010, 6'd2};
        v[4] = '{ALU_SHIFT, FUNC_SRA, 1'b1, 1'b0, 16'h00F0, 16'h0009, 16'h00F8, 4'b0010, 6'd2};
        v[5] = '{ALU_SHIFT, FUNC_SXT, 1'b0, 1'b0, 16'h1280, 16'h0000, 16'hFF80, 4'b0010, 6'd1};
        v[6] = '{ALU_SHIFT, FUNC_RRC, 1'b0, 1'b0, 16'h0003, 16'h0002, 16'h8000, 4'b1010, 6'd3};
        v[7] = '{ALU_SHIFT, FUNC_SRA, 1'b0, 1'b1, 16'h0001, 16'h000F, 16'h0000, 4'b0100, 6'd16};
        for (int i = 0; i < 8; i++) begin
            exec(v[i], r, f, lat, rl);
            checks++; if (r !== v[i].res) begin $display("FAIL shift[%0d] result got %h want %h", i, r, v[i].res); errors++; end
            checks++; if (f !== v[i].flg) begin $display("FAIL shift[%0d] flags got %b want %b", i, f, v[i].flg); errors++; end
            checks++; if (lat !== int'(v[i].lat)) begin $display("FAIL shift[%0d] latency got %0d want %0d", i, lat, v[i].lat); errors++; end
            checks++; if (rl !== int'(v[i].lat) - 1) begin $display("FAIL shift[%0d] ready_low got %0d want %0d", i, rl, int'(v[i].lat) - 1); errors++; end
        end
    endtask

    task automatic test_start_ignored;
        int dones = 0;
        int dcyc  = 0;
        @(negedge clk);
        block_sel = ALU_SHIFT; block_func = FUNC_SRA; byte_op = 1'b0; carry_in = 1'b0;
        src_a = 16'h8000; src_b = 16'h0004; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (done === 1'b1) begin dones++; dcyc = cyc; end
            if (cyc == 2) begin
                // A competing ADD while busy must be dropped
                block_sel = ALU_ARITH; block_func = FUNC_ADD; src_a = 16'h0001; src_b = 16'h0001;
            end
            start = (cyc == 2);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        checks++; if (dones !== 1) begin $display("FAIL busy_start done_count got %0d want 1", dones); errors++; end
        checks++; if (dcyc !== 5) begin $display("FAIL busy_start done_cycle got %0d want 5", dcyc); errors++; end
        checks++; if (result !== 16'hF800) begin $display("FAIL busy_start hold_result got %h want F800", result); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL busy_start done_low got %b want 0", done); errors++; end
    endtask

    task automatic test_reset_mid_shift;
        int dones = 0;
        @(negedge clk);
        block_sel = ALU_SHIFT; block_func = FUNC_SRA; byte_op = 1'b0; carry_in = 1'b0;
        src_a = 16'h8000; src_b = 16'h0004; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin $display("FAIL abort ready got %b want 1", ready); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL abort done got %b want 0", done); errors++; end
        checks++; if (result !== 16'h0000) begin $display("FAIL abort result got %h want 0000", result); errors++; end
        checks++; if ({carry, zero, neg, ovf} !== 4'b0000) begin
            $display("FAIL abort flags got %b want 0000", {carry, zero, neg, ovf}); errors++; end
        #2;
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin $display("FAIL abort late_done got %0d want 0", dones); errors++; end
    endtask

    task automatic test_func3;
        vec_t v [2];
        logic [15:0] r; logic [3:0] f; int lat, rl;
`ifdef XM_ALU_MUL_EN
        v[0] = '{ALU_SHIFT, FUNC_MUL, 1'b0, 1'b0, 16'h0012, 16'h0034, 16'h03A8, 4'b0000, 6'd17};
        v[1] = '{ALU_SHIFT, FUNC_MUL, 1'b1, 1'b0, 16'h0012, 16'h0034, 16'h00A8, 4'b1010, 6'd9};
`else
        v[0] = '{ALU_SHIFT, FUNC_MUL, 1'b0, 1'b1, 16'h0012, 16'h0034, 16'h0034, 4'b0000, 6'd1};
        v[1] = '{ALU_SHIFT, FUNC_MUL, 1'b1, 1'b1, 16'h8012, 16'h0000, 16'h0000, 4'b0000, 6'd1};
`endif
        for (int i = 0; i < 2; i++) begin
            exec(v[i], r, f, lat, rl);
            checks++; if (r !== v[i].res) begin $display("FAIL func3[%0d] result got %h want %h", i, r, v[i].res); errors++; end
            checks++; if (f !== v[i].flg) begin $display("FAIL func3[%0d] flags got %b want %b", i, f, v[i].flg); errors++; end
            checks++; if (lat !== int'(v[i].lat)) begin $display("FAIL func3[%0d] latency got %0d want %0d", i, lat, v[i].lat); errors++; end
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_logic_move;
        test_shift;
        test_start_ignored;
        test_reset_mid_shift;
        test_func3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xm_alu_mc.md
Name: xm_alu_mc

Overview:
Multi-cycle, parametrised successor to the single-cycle XMakina ALU. It keeps the four functional blocks (arithmetic, logic, shifter, move) and the byte/word modes, and registers all results and flags. It adds a start/done handshake and multi-bit shifts executed one bit per cycle. It sits between the control unit's execute state and the register file: the control unit issues `start`, then waits for `done`.

Parameters:
DATA_W, 16, datapath width (even, >= 16)
BYTE_W, 8, width of byte-mode operations
SHAMT_W, $clog2(DATA_W), width of shift-count field taken from src_b

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
ready  out  1  idle, can accept start
block_sel  in  2  0 arith, 1 logic, 2 shifter, 3 move
block_func  in  2  operation within block
byte_op  in  1  operate on low BYTE_W bits
carry_in  in  1  carry flag input
src_a  in  DATA_W  source operand / shifter operand
src_b  in  DATA_W  destination operand / shift count / move source
done  out  1  one-cycle pulse, result and flags valid
result  out  DATA_W  registered result
carry, zero, neg, ovf  out  1 each  registered flags

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; ready=1, done=0; result=0; all flags 0.
  - Reset mid-shift or mid-multiply aborts the operation; no done pulse is issued.
- Operand capture: all inputs are sampled on the clock edge where start&ready=1. A start while ready=0 is ignored.
- FSM states: IDLE, SHIFT, MUL (MUL exists only with the macro).
  - IDLE -> IDLE for single-cycle ops: result and flags registered at the capture edge; done=1 in the following cycle. Latency 1.
  - IDLE -> SHIFT for SRA/RRC with count N>0: one bit shifted per cycle, count decremented. Final result registered on the Nth SHIFT edge, then return to IDLE with done=1. Latency N+1; ready=0 for N cycles.
  - Shift count N=0: result=src_a, carry=carry_in. Latency 1.
- Outputs and flags hold their values until the next done.
- Byte mode:
  - Arith/logic/shift compute on bits [BYTE_W-1:0].
  - Upper bits pass through from the destination operand: src_b for arith/logic, src_a for shifter.
  - carry, neg and ovf are taken at bit BYTE_W-1.
  - zero tests the low byte only.
  - Shift count is masked to $clog2(BYTE_W) bits.
- Arithmetic:
  - func 0: ADD a+b.
  - func 1: ADDC a+b+carry_in.
  - func 2: SUB a+~b+1.
  - func 3: SUBC a+~b+carry_in.
  - carry = carry-out (1 = no borrow).
  - ovf = signed overflow.
  - zero and neg taken from the result.
- Logic:
  - func 0: XOR. func 1: AND. func 2: BIC (a&~b). func 3: BIS (a|b).
  - carry=carry_in, ovf=0; zero and neg from the result.
- Shifter:
  - func 0: SRA by N.
  - func 1: RRC by N through carry.
  - func 2: SXT, sign-extend low byte of src_a, single cycle.
  - func 3: see Optional Feature.
  - carry = last bit shifted out; ovf=0.
- Move (byte_op ignored):
  - func 0: MOV b.
  - func 1: MOVZ, zero-extend low byte of b.
  - func 2: MOVS, sign-extend low byte of b.
  - func 3: SWPB, swap the two bytes of b[15:0].
  - carry=carry_in, ovf=0.

Optional Feature:
Macro: XM_ALU_MUL_EN
- Defined: shifter func 3 = unsigned shift-add multiply.
  - Result is the low DATA_W bits (low BYTE_W bits in byte mode).
  - Runs in the MUL state, one partial product per cycle. Latency DATA_W+1 (BYTE_W+1 in byte mode).
  - carry=1 if the high half of the product is nonzero; ovf=0.
- Undefined: shifter func 3 is illegal and single-cycle; result=src_b, all flags 0.

Decomposition:
- Package xm_alu_pkg holds:
  - block_sel encodings (ALU_ARITH/LOGIC/SHIFT/MOVE);
  - per-block func encodings;
  - FSM state enum;
  - flag struct {carry,zero,neg,ovf}.
- Sub-module xm_alu_iter holds the iterative shift/multiply datapath: operand shift register, count register, accumulator, carry bit. The top module keeps the FSM, the single-cycle blocks and the output registers.

Test Plan:
1. ADD word a=007F b=007F -> result 00FE, flags 0, done one cycle after start; SUB same operands -> 0000, Z=1 C=1.
2. Byte ADD a=007F b=AB7F -> ABFE, N=1 V=1 C=0 Z=0.
3. SRA a=8000 b=0004 -> ready low 4 cycles, done at cycle 5, result F800, C=0; SRA with b=0000 -> 8000 at latency 1.
4. RRC a=0001 b=0001 carry_in=1 -> 8000, C=1; byte RRC a=AB01 b=0001 carry_in=1 -> AB80, N=1.
5. start pulsed during SHIFT is ignored (one done only); rst_n low at 2nd SHIFT cycle -> ready=1, done=0, result=0; MOVS b=00AA -> FFAA, SWPB b=12AB -> AB12.
6. With XM_ALU_MUL_EN: func 3 a=0012 b=0034 -> 03A8 at cycle 17, C=0. Without the macro -> result 0034, flags 0, latency 1.
